// File: rtl/oam_dma.sv
// Sprite-RAM DMA engine sitting on the CPU memory bus.
// A CPU write to DMA_REG_ADDR halts the CPU and copies XFER_LEN bytes from page
// {data,8'h00} to the fixed DEST_ADDR, one read cycle followed by one write cycle per byte.
// While dma_active is high the external bus mux selects the dma_* outputs over the CPU.
// XFER_LEN must lie in 1..256; idx is 9 bits so that a full 256-byte page fits.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004,
  parameter int unsigned XFER_LEN     = 256,
  parameter bit          ALIGN_ODD    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_write,
  input  logic [7:0]  bus_d_in,
  output logic        cpu_ready,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_d_out,
  output logic        dma_write,
  output logic        done
);

  // FSM encoding
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StHalt  = 3'd1;
  localparam logic [2:0] StAlign = 3'd2;
  localparam logic [2:0] StRead  = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;

  // Index of the final byte; the WRITE of this byte ends the transfer.
  localparam logic [8:0] LastIdx = 9'(XFER_LEN - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] page_q,  page_d;
  logic [8:0] idx_q,   idx_d;
  logic [7:0] buf_q,   buf_d;
  logic       done_q,  done_d;
  logic       odd_q;

  logic       trigger;
  logic       last_byte;

  // Only writes to the DMA register start a transfer; all other CPU writes pass untouched.
  assign trigger   = cpu_write && (cpu_addr == DMA_REG_ADDR);
  assign last_byte = (idx_q == LastIdx);

  // Next-state and datapath updates for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        // Triggers are only sampled here, so a write landing on the final WRITE is dropped.
        if (trigger) begin
          page_d  = cpu_d_out;
          idx_d   = '0;
          state_d = StHalt;
        end
      end
      StHalt: begin
        state_d = (ALIGN_ODD && odd_q) ? StAlign : StRead;
      end
      StAlign: begin
        state_d = StRead;
      end
      StRead: begin
        buf_d   = bus_d_in;
        state_d = StWrite;
      end
      StWrite: begin
        if (last_byte) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          idx_d   = idx_q + 9'd1;
          state_d = StRead;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset wins over any same-cycle trigger.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      page_q  <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
    end
  end

  // Free-running cycle parity used to decide whether an alignment cycle is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      odd_q <= 1'b0;
    end else begin
      odd_q <= ~odd_q;
    end
  end

  // Bus outputs decoded from state; HALT and ALIGN issue a harmless dummy read of the page base.
  always_comb begin
    cpu_ready  = (state_q == StIdle);
    dma_active = (state_q != StIdle);
    dma_write  = (state_q == StWrite);
    dma_d_out  = buf_q;
    done       = done_q;
    case (state_q)
      StHalt, StAlign: dma_addr = {page_q, 8'h00};
      // idx[7:0] only, so the source address wraps within the page and never bumps page.
      StRead:          dma_addr = {page_q, idx_q[7:0]};
      StWrite:         dma_addr = DEST_ADDR;
      default:         dma_addr = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a default 256-byte instance and a 4-byte instance share one RAM model.
// Expected bus traffic is derived from the transfer rules (page, length, alignment parity).
module tb_oam_dma;

  localparam logic [15:0] DmaRegAddr = 16'h4014;
  localparam logic [15:0] DestAddr   = 16'h2004;

  typedef logic [7:0]  q8_t [$];
  typedef logic [15:0] q16_t [$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_d_out = 8'h00;
  logic        cpu_write = 1'b0;
  logic        cpu_write4 = 1'b0;
  logic [7:0]  bus_d_in, bus_d_in4;
  logic        cpu_ready, dma_active, dma_write, done;
  logic [15:0] dma_addr;
  logic [7:0]  dma_d_out;
  logic        cpu_ready4, dma_active4, dma_write4, done4;
  logic [15:0] dma_addr4;
  logic [7:0]  dma_d_out4;

  logic [7:0]  mem [0:65535];
  int unsigned cyc;
  int          checks = 0;
  int          errors = 0;
  q8_t         wq, ewq;
  q16_t        rq, erq;
  int          bad_waddr, act_bad;
  bit          saw_zero;
  bit          exp_align;

  always #5 clk = ~clk;

  // Model of the cycle parity: 0 in the first cycle after reset, toggling thereafter.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  assign bus_d_in  = mem[dma_addr];
  assign bus_d_in4 = mem[dma_addr4];

  oam_dma u_dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_d_out  (cpu_d_out),
    .cpu_write  (cpu_write),
    .bus_d_in   (bus_d_in),
    .cpu_ready  (cpu_ready),
    .dma_active (dma_active),
    .dma_addr   (dma_addr),
    .dma_d_out  (dma_d_out),
    .dma_write  (dma_write),
    .done       (done)
  );

  oam_dma #(.XFER_LEN(4)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_d_out  (cpu_d_out),
    .cpu_write  (cpu_write4),
    .bus_d_in   (bus_d_in4),
    .cpu_ready  (cpu_ready4),
    .dma_active (dma_active4),
    .dma_addr   (dma_addr4),
    .dma_d_out  (dma_d_out4),
    .dma_write  (dma_write4),
    .done       (done4)
  );

  function automatic int diff8(input q8_t got, input q8_t want);
    int n;
    n = (got.size() != want.size()) ? 1 : 0;
    for (int i = 0; i < got.size() && i < want.size(); i++) if (got[i] !== want[i]) n++;
    return n;
  endfunction

  function automatic int diff16(input q16_t got, input q16_t want);
    int n;
    n = (got.size() != want.size()) ? 1 : 0;
    for (int i = 0; i < got.size() && i < want.size(); i++) if (got[i] !== want[i]) n++;
    return n;
  endfunction

  // Expected traffic: (1+align) dummy reads of the page base, then read {page,i} / write byte i.
  task automatic build_expect(input logic [7:0] page, input int len, input bit align);
    ewq.delete();
    erq.delete();
    erq.push_back({page, 8'h00});
    if (align) erq.push_back({page, 8'h00});
    for (int i = 0; i < len; i++) begin
      erq.push_back({page, 8'(i)});
      ewq.push_back(mem[{page, 8'(i)}]);
    end
  endtask

  // Step until the HALT cycle following a trigger issued now would have the given parity.
  task automatic wait_parity(input bit halt_odd);
    @(posedge clk); #1;
    if (cyc[0] == halt_odd) begin
      @(posedge clk); #1;
    end
  endtask

  // Present a DMA-register write for the current cycle (called just after a clock edge).
  task automatic trigger(input bit sel, input logic [7:0] page);
    cpu_addr  = DmaRegAddr;
    cpu_d_out = page;
    if (sel) cpu_write4 = 1'b1;
    else     cpu_write  = 1'b1;
    exp_align = (cyc[0] == 1'b0);
  endtask

  task automatic fill_page(input logic [7:0] page);
    for (int i = 0; i < 256; i++) mem[{page, 8'(i)}] = 8'($urandom);
  endtask

  // Record bus activity of one transfer until cpu_ready comes back, plus a short tail.
  task automatic observe(input bit sel, input bit hold, input int max_cyc,
                         output int low, output int dones, output bit to);
    logic r, act, wr, dn;
    logic [15:0] a;
    logic [7:0] d;
    bit started;
    int n;
    wq.delete();
    rq.delete();
    bad_waddr = 0; act_bad = 0; saw_zero = 0;
    low = 0; dones = 0; to = 0; started = 0; n = 0;
    forever begin
      @(posedge clk); #1;
      if (hold) cpu_d_out = 8'h44;
      else begin
        cpu_write  = 1'b0;
        cpu_write4 = 1'b0;
      end
      r   = sel ? cpu_ready4 : cpu_ready;
      act = sel ? dma_active4 : dma_active;
      wr  = sel ? dma_write4 : dma_write;
      a   = sel ? dma_addr4 : dma_addr;
      d   = sel ? dma_d_out4 : dma_d_out;
      dn  = sel ? done4 : done;
      if (act === r) act_bad++;
      if (!r) begin
        started = 1;
        low++;
        if (a == 16'h0000) saw_zero = 1;
        if (wr) begin
          wq.push_back(d);
          if (a !== DestAddr) bad_waddr++;
        end else begin
          rq.push_back(a);
        end
      end
      if (dn) dones++;
      if (started && r) break;
      n++;
      if (n > max_cyc) begin
        to = 1;
        break;
      end
    end
    cpu_write  = 1'b0;
    cpu_write4 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (sel ? done4 : done) dones++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cpu_ready !== 1'b1 || dma_active !== 1'b0 || dma_write !== 1'b0 || done !== 1'b0 ||
        dma_addr !== 16'h0000 || dma_d_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b act=%b wr=%b done=%b addr=%h d=%h, want 1 0 0 0 0000 00",
               cpu_ready, dma_active, dma_write, done, dma_addr, dma_d_out);
    end
    // A trigger coinciding with reset must be discarded.
    trigger(1'b0, 8'h09);
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_write = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cpu_ready !== 1'b1 || dma_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: got rdy=%b act=%b, want rdy=1 act=0", cpu_ready, dma_active);
    end
  endtask

  task automatic test_idle_snoop();
    int bad;
    logic [15:0] addrs [3];
    addrs[0] = 16'h4013;
    addrs[1] = 16'h4015;
    addrs[2] = DestAddr;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      cpu_addr = addrs[k];
      cpu_d_out = 8'h55;
      cpu_write = 1'b1;
      @(posedge clk); #1;
      if (cpu_ready !== 1'b1 || dma_active !== 1'b0) bad++;
    end
    cpu_write = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (cpu_ready !== 1'b1 || dma_active !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_snoop: got %0d busy cycles, want 0", bad);
    end
  endtask

  task automatic test_even();
    int low, dones;
    bit to;
    for (int i = 0; i < 256; i++) mem[{8'h02, 8'(i)}] = 8'(i) ^ 8'hA5;
    wait_parity(1'b0);
    trigger(1'b0, 8'h02);
    build_expect(8'h02, 256, exp_align);
    observe(1'b0, 1'b0, 700, low, dones, to);
    checks++;
    if (to || low != 513) begin
      errors++;
      $display("FAIL even_latency: got %0d low cycles (timeout=%0d), want 513", low, to);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL even_done: got %0d pulses, want 1", dones);
    end
    checks++;
    if (diff8(wq, ewq) != 0 || bad_waddr != 0) begin
      errors++;
      $display("FAIL even_writes: got %0d writes, %0d data diffs, %0d bad addrs; want 256 0 0",
               wq.size(), diff8(wq, ewq), bad_waddr);
    end
    checks++;
    if (diff16(rq, erq) != 0 || act_bad != 0) begin
      errors++;
      $display("FAIL even_reads: got %0d reads, %0d addr diffs, %0d active errs; want %0d 0 0",
               rq.size(), diff16(rq, erq), act_bad, erq.size());
    end
  endtask

  task automatic test_odd_align();
    int low, dones;
    bit to;
    wait_parity(1'b1);
    trigger(1'b0, 8'h02);
    build_expect(8'h02, 256, exp_align);
    observe(1'b0, 1'b0, 700, low, dones, to);
    checks++;
    if (to || low != 514) begin
      errors++;
      $display("FAIL odd_latency: got %0d low cycles (timeout=%0d), want 514", low, to);
    end
    checks++;
    if (rq.size() < 3 || rq[2] !== 16'h0200 || diff16(rq, erq) != 0) begin
      errors++;
      $display("FAIL odd_reads: got %0d reads, %0d addr diffs, want %0d 0 with first READ 0200",
               rq.size(), diff16(rq, erq), erq.size());
    end
    checks++;
    if (diff8(wq, ewq) != 0 || dones != 1) begin
      errors++;
      $display("FAIL odd_writes: got %0d data diffs, %0d done; want 0 1", diff8(wq, ewq), dones);
    end
  endtask

  task automatic test_page_ff();
    int low, dones;
    bit to;
    fill_page(8'hFF);
    mem[16'hFFFF] = 8'h3C;
    mem[16'h0000] = 8'hC3;
    wait_parity(1'($urandom));
    trigger(1'b0, 8'hFF);
    build_expect(8'hFF, 256, exp_align);
    observe(1'b0, 1'b0, 700, low, dones, to);
    checks++;
    if (rq.size() == 0 || rq[rq.size()-1] !== 16'hFFFF || saw_zero) begin
      errors++;
      $display("FAIL pageff_wrap: got last read %h, zero access %0d; want FFFF 0",
               (rq.size() == 0) ? 16'hxxxx : rq[rq.size()-1], saw_zero);
    end
    checks++;
    if (wq.size() == 0 || wq[wq.size()-1] !== 8'h3C || diff8(wq, ewq) != 0) begin
      errors++;
      $display("FAIL pageff_data: got last write %h, %0d diffs; want 3C 0",
               (wq.size() == 0) ? 8'hxx : wq[wq.size()-1], diff8(wq, ewq));
    end
    checks++;
    if (to || low != 513 + int'(exp_align) || dones != 1) begin
      errors++;
      $display("FAIL pageff_latency: got %0d low %0d done, want %0d 1",
               low, dones, 513 + int'(exp_align));
    end
  endtask

  task automatic test_reset_mid();
    int nw, n, low, dones;
    bit to;
    fill_page(8'h05);
    trigger(1'b0, 8'h05);
    nw = 0;
    n = 0;
    while (nw < 100 && n < 1000) begin
      @(posedge clk); #1;
      cpu_write = 1'b0;
      n++;
      if (dma_write) nw++;
    end
    checks++;
    if (nw != 100) begin
      errors++;
      $display("FAIL midreset_reach: got %0d writes, want 100", nw);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (cpu_ready !== 1'b1 || dma_active !== 1'b0 || dma_write !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: got rdy=%b act=%b wr=%b done=%b, want 1 0 0 0",
               cpu_ready, dma_active, dma_write, done);
    end
    nw = 0;
    dones = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (dma_write) nw++;
      if (done) dones++;
    end
    checks++;
    if (nw != 0 || dones != 0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d writes %0d done, want 0 0", nw, dones);
    end
    fill_page(8'h03);
    trigger(1'b0, 8'h03);
    build_expect(8'h03, 256, exp_align);
    observe(1'b0, 1'b0, 700, low, dones, to);
    checks++;
    if (to || low != 513 + int'(exp_align) || dones != 1 || diff8(wq, ewq) != 0) begin
      errors++;
      $display("FAIL midreset_rerun: got low=%0d done=%0d diffs=%0d, want %0d 1 0",
               low, dones, diff8(wq, ewq), 513 + int'(exp_align));
    end
  endtask

  // Trigger held high for the whole transfer (with another page) must change nothing.
  task automatic test_back_to_back();
    int low, dones, bad;
    bit to;
    fill_page(8'h11);
    fill_page(8'h44);
    trigger(1'b0, 8'h11);
    build_expect(8'h11, 256, exp_align);
    observe(1'b0, 1'b1, 700, low, dones, to);
    checks++;
    if (to || low != 513 + int'(exp_align) || diff8(wq, ewq) != 0 || diff16(rq, erq) != 0) begin
      errors++;
      $display("FAIL held_trigger: got low=%0d wdiff=%0d rdiff=%0d, want %0d 0 0",
               low, diff8(wq, ewq), diff16(rq, erq), 513 + int'(exp_align));
    end
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (cpu_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || dones != 1) begin
      errors++;
      $display("FAIL retrigger_on_exit: got %0d busy cycles %0d done, want 0 1", bad, dones);
    end
  endtask

  task automatic test_random();
    int low, dones;
    bit to;
    logic [7:0] page;
    for (int k = 0; k < 3; k++) begin
      page = 8'($urandom);
      fill_page(page);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      trigger(1'b0, page);
      build_expect(page, 256, exp_align);
      observe(1'b0, 1'b0, 700, low, dones, to);
      checks++;
      if (to || low != 513 + int'(exp_align) || dones != 1 || diff8(wq, ewq) != 0 ||
          diff16(rq, erq) != 0 || bad_waddr != 0) begin
        errors++;
        $display("FAIL random_xfer page %h: got low=%0d done=%0d wdiff=%0d rdiff=%0d badw=%0d, want %0d 1 0 0 0",
                 page, low, dones, diff8(wq, ewq), diff16(rq, erq), bad_waddr,
                 513 + int'(exp_align));
      end
    end
  endtask

  task automatic test_len4();
    int low, dones;
    bit to;
    fill_page(8'h07);
    for (int p = 0; p < 2; p++) begin
      wait_parity(1'(p));
      trigger(1'b1, 8'h07);
      build_expect(8'h07, 4, exp_align);
      observe(1'b1, 1'b0, 40, low, dones, to);
      checks++;
      if (to || low != 9 + int'(exp_align) || dones != 1) begin
        errors++;
        $display("FAIL len4_latency: got low=%0d done=%0d, want %0d 1", low, dones,
                 9 + int'(exp_align));
      end
      checks++;
      if (diff8(wq, ewq) != 0 || diff16(rq, erq) != 0 || bad_waddr != 0) begin
        errors++;
        $display("FAIL len4_traffic: got %0d writes wdiff=%0d rdiff=%0d badw=%0d, want 4 0 0 0",
                 wq.size(), diff8(wq, ewq), diff16(rq, erq), bad_waddr);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_idle_snoop();
    test_even();
    test_odd_align();
    test_page_ff();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_len4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
